// File: rtl/tpu_host_seq.sv
// Host-side job sequencer for an MMIO matrix-multiply accelerator: writes A and B,
// kicks CTRL, polls STATUS for done (with timeout) and reads C back into c_flat_out.
module tpu_host_seq #(
    parameter int unsigned N           = 4,
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned SUM_W       = 32,
    parameter int unsigned POLL_MAX    = 1024,
    parameter logic [15:0] CTRL_ADDR   = 16'h0000,
    parameter logic [15:0] STATUS_ADDR = 16'h0004,
    parameter logic [15:0] A_BASE      = 16'h0100,
    parameter logic [15:0] B_BASE      = 16'h0200,
    parameter logic [15:0] C_BASE      = 16'h0300
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    job_start,
    input  logic [DATA_W*N*N-1:0]   a_flat_in,
    input  logic [DATA_W*N*N-1:0]   b_flat_in,
    output logic [SUM_W*N*N-1:0]    c_flat_out,
    output logic                    job_busy,
    output logic                    job_done,
    output logic                    job_err,
    output logic                    mmio_wr,
    output logic                    mmio_rd,
    output logic [15:0]             mmio_addr,
    output logic [31:0]             mmio_wdata,
    output logic [3:0]              mmio_wstrb,
    input  logic [31:0]             mmio_rdata,
    input  logic                    mmio_ready
);
    localparam int unsigned NN     = N * N;
    localparam int unsigned IDX_W  = $clog2(NN) + 1;
    localparam int unsigned POLL_W = $clog2(POLL_MAX + 1);
    localparam int unsigned MAT_W  = DATA_W * NN;
    localparam int unsigned C_W    = SUM_W * NN;

    typedef enum logic [2:0] {
        S_IDLE, S_WR_A, S_WR_B, S_START, S_POLL, S_RD_C, S_FIN
    } state_t;

    state_t             r_state, w_state;
    logic [IDX_W-1:0]   r_idx, w_idx;
    logic [POLL_W-1:0]  r_poll, w_poll;
    logic [MAT_W-1:0]   r_a, w_a, r_b, w_b;
    logic [C_W-1:0]     r_c, w_c;
    logic               r_wr, w_wr, r_rd, w_rd;
    logic [15:0]        r_addr, w_addr;
    logic [31:0]        r_wdata, w_wdata;
    logic [3:0]         r_wstrb, w_wstrb;
    logic               r_busy, w_busy, r_done, w_done, r_err, w_err;

    logic               w_req;
    logic               w_last;
    logic [15:0]        w_offs;
    logic [DATA_W-1:0]  w_a_elem, w_b_elem;

    assign w_req    = r_wr | r_rd;
    assign w_last   = (r_idx == IDX_W'(NN - 1));
    assign w_offs   = 16'(r_idx) << 2;
    assign w_a_elem = r_a[int'(r_idx)*DATA_W +: DATA_W];
    assign w_b_elem = r_b[int'(r_idx)*DATA_W +: DATA_W];

    // Each request is held until mmio_ready, then dropped for one cycle before the next.
    always_comb begin
        w_state = r_state;
        w_idx   = r_idx;
        w_poll  = r_poll;
        w_a     = r_a;
        w_b     = r_b;
        w_c     = r_c;
        w_wr    = r_wr;
        w_rd    = r_rd;
        w_addr  = r_addr;
        w_wdata = r_wdata;
        w_wstrb = r_wstrb;
        w_busy  = r_busy;
        w_done  = 1'b0;
        w_err   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (job_start) begin
                    w_a     = a_flat_in;
                    w_b     = b_flat_in;
                    w_busy  = 1'b1;
                    w_idx   = '0;
                    w_poll  = '0;
                    w_state = S_WR_A;
                end
            end
            S_WR_A, S_WR_B: begin
                if (!w_req) begin
                    w_wr    = 1'b1;
                    w_wstrb = 4'hF;
                    w_addr  = ((r_state == S_WR_A) ? A_BASE : B_BASE) + w_offs;
                    w_wdata = (r_state == S_WR_A) ? 32'(w_a_elem) : 32'(w_b_elem);
                end else if (mmio_ready) begin
                    w_wr = 1'b0;
                    if (w_last) begin
                        w_idx   = '0;
                        w_state = (r_state == S_WR_A) ? S_WR_B : S_START;
                    end else begin
                        w_idx = r_idx + IDX_W'(1);
                    end
                end
            end
            S_START: begin
                if (!w_req) begin
                    w_wr    = 1'b1;
                    w_wstrb = 4'hF;
                    w_addr  = CTRL_ADDR;
                    w_wdata = 32'h1;
                end else if (mmio_ready) begin
                    w_wr    = 1'b0;
                    w_state = S_POLL;
                end
            end
            S_POLL: begin
                if (!w_req) begin
                    w_rd    = 1'b1;
                    w_wstrb = 4'h0;
                    w_wdata = 32'h0;
                    w_addr  = STATUS_ADDR;
                end else if (mmio_ready) begin
                    w_rd = 1'b0;
                    if (mmio_rdata[1]) begin
                        w_idx   = '0;
                        w_state = S_RD_C;
                    end else if (r_poll == POLL_W'(POLL_MAX - 1)) begin
                        w_poll  = POLL_W'(POLL_MAX);
                        w_err   = 1'b1;
                        w_state = S_FIN;
                    end else begin
                        w_poll = r_poll + POLL_W'(1);
                    end
                end
            end
            S_RD_C: begin
                if (!w_req) begin
                    w_rd    = 1'b1;
                    w_wstrb = 4'h0;
                    w_wdata = 32'h0;
                    w_addr  = C_BASE + w_offs;
                end else if (mmio_ready) begin
                    w_rd = 1'b0;
                    w_c[int'(r_idx)*SUM_W +: SUM_W] = mmio_rdata[SUM_W-1:0];
                    if (w_last) begin
                        w_done  = 1'b1;
                        w_state = S_FIN;
                    end else begin
                        w_idx = r_idx + IDX_W'(1);
                    end
                end
            end
            S_FIN: begin
                w_busy  = 1'b0;
                w_idx   = '0;
                w_poll  = '0;
                w_state = S_IDLE;
            end
            default: w_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_poll  <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_c     <= '0;
            r_wr    <= 1'b0;
            r_rd    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_wstrb <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state;
            r_idx   <= w_idx;
            r_poll  <= w_poll;
            r_a     <= w_a;
            r_b     <= w_b;
            r_c     <= w_c;
            r_wr    <= w_wr;
            r_rd    <= w_rd;
            r_addr  <= w_addr;
            r_wdata <= w_wdata;
            r_wstrb <= w_wstrb;
            r_busy  <= w_busy;
            r_done  <= w_done;
            r_err   <= w_err;
        end
    end

    assign c_flat_out = r_c;
    assign job_busy   = r_busy;
    assign job_done   = r_done;
    assign job_err    = r_err;
    assign mmio_wr    = r_wr;
    assign mmio_rd    = r_rd;
    assign mmio_addr  = r_addr;
    assign mmio_wdata = r_wdata;
    assign mmio_wstrb = r_wstrb;

endmodule

// File: tb/tb_tpu_host_seq.sv
// Bench for tpu_host_seq: an MMIO accelerator model answers the DUT, and every job is
// checked against the expected transaction list and the matrix product of its inputs.
`timescale 1ns/1ps
module tb_tpu_host_seq;
    localparam int unsigned N        = 4;
    localparam int unsigned NN       = 16;
    localparam int unsigned DATA_W   = 8;
    localparam int unsigned SUM_W    = 32;
    localparam int unsigned POLL_MAX = 8;
    localparam logic [15:0] CTRL_ADDR   = 16'h0000;
    localparam logic [15:0] STATUS_ADDR = 16'h0004;
    localparam logic [15:0] A_BASE      = 16'h0100;
    localparam logic [15:0] B_BASE      = 16'h0200;
    localparam logic [15:0] C_BASE      = 16'h0300;

    logic                   clk = 1'b0;
    logic                   rst, job_start;
    logic [DATA_W*NN-1:0]   a_flat, b_flat;
    logic [SUM_W*NN-1:0]    c_flat;
    logic                   job_busy, job_done, job_err;
    logic                   mmio_wr, mmio_rd, mmio_ready;
    logic [15:0]            mmio_addr;
    logic [31:0]            mmio_wdata, mmio_rdata;
    logic [3:0]             mmio_wstrb;

    always #5 clk = ~clk;

    tpu_host_seq #(
        .N(N), .DATA_W(DATA_W), .SUM_W(SUM_W), .POLL_MAX(POLL_MAX),
        .CTRL_ADDR(CTRL_ADDR), .STATUS_ADDR(STATUS_ADDR),
        .A_BASE(A_BASE), .B_BASE(B_BASE), .C_BASE(C_BASE)
    ) dut (
        .clk(clk), .rst(rst), .job_start(job_start),
        .a_flat_in(a_flat), .b_flat_in(b_flat), .c_flat_out(c_flat),
        .job_busy(job_busy), .job_done(job_done), .job_err(job_err),
        .mmio_wr(mmio_wr), .mmio_rd(mmio_rd), .mmio_addr(mmio_addr),
        .mmio_wdata(mmio_wdata), .mmio_wstrb(mmio_wstrb),
        .mmio_rdata(mmio_rdata), .mmio_ready(mmio_ready)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct packed {
        logic        wr;
        logic [15:0] addr;
        logic [31:0] wdata;
    } txn_t;

    txn_t        exp_q[$];
    logic [31:0] dev_a[NN];
    logic [31:0] dev_b[NN];
    logic [31:0] dev_c[NN];
    int          dev_polls_left;
    bit          dev_started;
    int          stall_mode;

    bit          pend, prev_req, prev_pulse, fin_seen;
    txn_t        cap;
    logic [3:0]  cap_strb;
    logic [53:0] prev_vec;
    int          stall_left;
    int          done_cnt, err_cnt, wr_cnt, c_rd_cnt, st_rd_cnt;

    function automatic logic [31:0] dev_read(input logic [15:0] addr);
        int idx;
        logic [31:0] v;
        v = $urandom;
        if (addr == STATUS_ADDR)
            return (v & ~32'h2) | ((dev_started && dev_polls_left == 0) ? 32'h2 : 32'h0);
        idx = int'((addr - C_BASE) >> 2);
        if (addr >= C_BASE && idx < int'(NN)) return dev_c[idx];
        return v;
    endfunction

    // Compares one completed transaction with the expected list and applies its effect on the accelerator.
    task automatic complete(input txn_t t, input logic [3:0] strb);
        txn_t e;
        int   idx;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_txn: got wr=%0d addr=%0h, expected no transaction", t.wr, t.addr);
            return;
        end
        e = exp_q.pop_front();
        chk("txn_kind", 64'(t.wr), 64'(e.wr));
        chk("txn_addr", 64'(t.addr), 64'(e.addr));
        if (t.wr) begin
            chk("txn_wdata", 64'(t.wdata), 64'(e.wdata));
            chk("txn_wstrb", 64'(strb), 64'hF);
            wr_cnt++;
            if (t.addr >= A_BASE && t.addr < B_BASE) begin
                idx = int'((t.addr - A_BASE) >> 2);
                if (idx < int'(NN)) dev_a[idx] = t.wdata;
            end else if (t.addr >= B_BASE && t.addr < C_BASE) begin
                idx = int'((t.addr - B_BASE) >> 2);
                if (idx < int'(NN)) dev_b[idx] = t.wdata;
            end else if (t.addr == CTRL_ADDR && t.wdata == 32'h1) begin
                for (int r = 0; r < int'(N); r++)
                    for (int c = 0; c < int'(N); c++) begin
                        dev_c[r*N+c] = 0;
                        for (int k = 0; k < int'(N); k++)
                            dev_c[r*N+c] += dev_a[r*N+k] * dev_b[k*N+c];
                    end
                dev_started = 1'b1;
            end
        end else if (t.addr == STATUS_ADDR) begin
            st_rd_cnt++;
            if (dev_polls_left > 0) dev_polls_left--;
        end else begin
            c_rd_cnt++;
        end
    endtask

    // Accelerator responder and per-cycle protocol checker, working mid-cycle.
    always @(negedge clk) begin
        if (rst) begin
            mmio_ready = 1'b0;
            pend       = 1'b0;
            prev_req   = 1'b0;
            prev_pulse = 1'b0;
            stall_left = 0;
        end else begin
            if (prev_pulse) chk("busy_drop_after_fin", 64'(job_busy), 64'h0);
            prev_pulse = job_done | job_err;
            if (job_done | job_err) begin
                chk("busy_during_fin", 64'(job_busy), 64'h1);
                chk("done_err_exclusive", 64'(job_done & job_err), 64'h0);
                if (job_done) done_cnt++;
                if (job_err) err_cnt++;
                fin_seen = 1'b1;
            end
            if (pend) begin
                pend = 1'b0;
                chk("idle_after_completion", 64'(mmio_wr | mmio_rd), 64'h0);
                complete(cap, cap_strb);
            end else if (prev_req) begin
                chk("request_held_stable",
                    64'({mmio_wr, mmio_rd, mmio_addr, mmio_wdata, mmio_wstrb}), 64'(prev_vec));
            end
            if (mmio_wr | mmio_rd) begin
                chk("wr_rd_exclusive", 64'(mmio_wr & mmio_rd), 64'h0);
                if (!prev_req)
                    stall_left = (stall_mode < 0) ? int'($urandom_range(0, 3)) : stall_mode;
                if (stall_left == 0) begin
                    mmio_ready = 1'b1;
                    mmio_rdata = dev_read(mmio_addr);
                    pend       = 1'b1;
                    prev_req   = 1'b0;
                    cap.wr     = mmio_wr;
                    cap.addr   = mmio_addr;
                    cap.wdata  = mmio_wdata;
                    cap_strb   = mmio_wstrb;
                end else begin
                    mmio_ready = 1'b0;
                    mmio_rdata = $urandom;
                    stall_left--;
                    prev_req   = 1'b1;
                    prev_vec   = {mmio_wr, mmio_rd, mmio_addr, mmio_wdata, mmio_wstrb};
                end
            end else begin
                mmio_ready = 1'b0;
                prev_req   = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DATA_W*NN-1:0] rand_mat();
        logic [DATA_W*NN-1:0] m;
        for (int i = 0; i < int'(NN); i++) m[i*DATA_W +: DATA_W] = DATA_W'($urandom);
        return m;
    endfunction

    // Builds the expected transaction list from the inputs, arms the accelerator and starts the job.
    task automatic start_job(input logic [DATA_W*NN-1:0] a, input logic [DATA_W*NN-1:0] b,
                             input int stall, input int polls, input bit timeout);
        txn_t t;
        int   n_status;
        exp_q.delete();
        for (int i = 0; i < int'(NN); i++) begin
            t.wr = 1'b1; t.addr = A_BASE + 16'(4*i); t.wdata = 32'(a[i*DATA_W +: DATA_W]);
            exp_q.push_back(t);
        end
        for (int i = 0; i < int'(NN); i++) begin
            t.wr = 1'b1; t.addr = B_BASE + 16'(4*i); t.wdata = 32'(b[i*DATA_W +: DATA_W]);
            exp_q.push_back(t);
        end
        t.wr = 1'b1; t.addr = CTRL_ADDR; t.wdata = 32'h1;
        exp_q.push_back(t);
        n_status = timeout ? int'(POLL_MAX) : polls + 1;
        for (int i = 0; i < n_status; i++) begin
            t.wr = 1'b0; t.addr = STATUS_ADDR; t.wdata = 32'h0;
            exp_q.push_back(t);
        end
        if (!timeout)
            for (int i = 0; i < int'(NN); i++) begin
                t.wr = 1'b0; t.addr = C_BASE + 16'(4*i); t.wdata = 32'h0;
                exp_q.push_back(t);
            end
        dev_started    = 1'b0;
        dev_polls_left = timeout ? 1000000 : polls;
        stall_mode     = stall;
        done_cnt = 0; err_cnt = 0; wr_cnt = 0; c_rd_cnt = 0; st_rd_cnt = 0;
        fin_seen = 1'b0;
        a_flat    = a;
        b_flat    = b;
        job_start = 1'b1;
        tick();
        job_start = 1'b0;
        chk("busy_rise", 64'(job_busy), 64'h1);
        a_flat = ~a;
        b_flat = ~b;
    endtask

    task automatic finish_job(input logic [DATA_W*NN-1:0] a, input logic [DATA_W*NN-1:0] b,
                              input int polls, input bit timeout);
        logic [31:0] sum;
        for (int k = 0; k < 5000 && !fin_seen; k++) tick();
        if (!fin_seen) begin
            n_checks++;
            n_fail++;
            $display("FAIL job_end_wait: got no done/err pulse within 5000 cycles, expected one");
        end
        repeat (2) tick();
        chk("busy_low_after_job", 64'(job_busy), 64'h0);
        chk("done_pulses", 64'(done_cnt), timeout ? 64'h0 : 64'h1);
        chk("err_pulses", 64'(err_cnt), timeout ? 64'h1 : 64'h0);
        chk("txns_left", 64'(exp_q.size()), 64'h0);
        chk("write_count", 64'(wr_cnt), 64'(2*NN + 1));
        chk("status_reads", 64'(st_rd_cnt), timeout ? 64'(POLL_MAX) : 64'(polls + 1));
        chk("c_reads", 64'(c_rd_cnt), timeout ? 64'h0 : 64'(NN));
        if (!timeout)
            for (int r = 0; r < int'(N); r++)
                for (int c = 0; c < int'(N); c++) begin
                    sum = 0;
                    for (int k = 0; k < int'(N); k++)
                        sum += 32'(a[(r*N+k)*DATA_W +: DATA_W]) * 32'(b[(k*N+c)*DATA_W +: DATA_W]);
                    chk("c_elem", 64'(c_flat[(r*N+c)*SUM_W +: SUM_W]), 64'(sum));
                end
    endtask

    task automatic run_job(input logic [DATA_W*NN-1:0] a, input logic [DATA_W*NN-1:0] b,
                           input int stall, input int polls, input bit timeout);
        start_job(a, b, stall, polls, timeout);
        finish_job(a, b, polls, timeout);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, 64'(job_busy), 64'h0);
        chk({tag, "_done"}, 64'(job_done), 64'h0);
        chk({tag, "_err"}, 64'(job_err), 64'h0);
        chk({tag, "_wr_rd"}, 64'({mmio_wr, mmio_rd}), 64'h0);
        chk({tag, "_addr"}, 64'(mmio_addr), 64'h0);
        chk({tag, "_wdata"}, 64'(mmio_wdata), 64'h0);
        chk({tag, "_wstrb"}, 64'(mmio_wstrb), 64'h0);
        chk({tag, "_c_zero"}, 64'(c_flat == '0), 64'h1);
    endtask

    initial begin
        logic [DATA_W*NN-1:0] a_id, b_id, a_r, b_r, a_one, b_two;
        logic [SUM_W*NN-1:0]  c_ident;
        bit                   seen;

        rst = 1'b1; job_start = 1'b0; a_flat = '0; b_flat = '0;
        stall_mode = 0;
        repeat (3) tick();
        chk_all_zero("reset");
        rst = 1'b0;
        tick();

        // Identity A, B elements i+1: C must equal B.
        a_id = '0; b_id = '0;
        for (int i = 0; i < int'(N); i++) a_id[(i*N+i)*DATA_W +: DATA_W] = 8'd1;
        for (int i = 0; i < int'(NN); i++) b_id[i*DATA_W +: DATA_W] = DATA_W'(i + 1);
        run_job(a_id, b_id, 0, 2, 1'b0);
        for (int i = 0; i < int'(NN); i++)
            chk("ident_c_literal", 64'(c_flat[i*SUM_W +: SUM_W]), 64'(i + 1));
        c_ident = c_flat;

        // Three stall cycles on every request.
        run_job(a_id, b_id, 3, 1, 1'b0);
        chk("backpressure_c_same", 64'(c_flat == c_ident), 64'h1);

        // STATUS never reports done.
        a_r = rand_mat(); b_r = rand_mat();
        run_job(a_r, b_r, -1, 0, 1'b1);
        chk("timeout_c_kept", 64'(c_flat == c_ident), 64'h1);

        // Second job_start while B is being written must be ignored.
        a_r = rand_mat(); b_r = rand_mat();
        start_job(a_r, b_r, -1, 3, 1'b0);
        seen = 1'b0;
        for (int k = 0; k < 2000 && !seen; k++) begin
            if (mmio_wr && mmio_addr >= B_BASE && mmio_addr < C_BASE) seen = 1'b1;
            else tick();
        end
        chk("reached_wr_b", 64'(seen), 64'h1);
        a_flat = rand_mat();
        job_start = 1'b1;
        tick();
        job_start = 1'b0;
        finish_job(a_r, b_r, 3, 1'b0);

        // Reset in the middle of polling.
        a_one = '0; b_two = '0;
        for (int i = 0; i < int'(NN); i++) a_one[i*DATA_W +: DATA_W] = 8'd1;
        for (int i = 0; i < int'(N); i++) b_two[(i*N+i)*DATA_W +: DATA_W] = 8'd2;
        start_job(a_one, b_two, 1, 6, 1'b0);
        seen = 1'b0;
        for (int k = 0; k < 2000 && !seen; k++) begin
            if (mmio_rd && mmio_addr == STATUS_ADDR) seen = 1'b1;
            else tick();
        end
        chk("reached_poll", 64'(seen), 64'h1);
        rst = 1'b1;
        tick();
        chk_all_zero("midreset");
        rst = 1'b0;
        exp_q.delete();
        repeat (10) tick();
        chk("midreset_no_pulse", 64'(done_cnt + err_cnt), 64'h0);
        chk("midreset_idle", 64'({job_busy, mmio_wr, mmio_rd}), 64'h0);
        run_job(a_one, b_two, 0, 0, 1'b0);
        for (int i = 0; i < int'(NN); i++)
            chk("after_reset_c_all_2", 64'(c_flat[i*SUM_W +: SUM_W]), 64'h2);

        // Random jobs with random backpressure and poll latency.
        for (int j = 0; j < 4; j++) begin
            a_r = rand_mat(); b_r = rand_mat();
            run_job(a_r, b_r, -1, int'($urandom_range(0, 5)), 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected bench to finish");
        $fatal(1, "watchdog expired");
    end

endmodule
